buffer_mult_seq: RTL and testbench
==================================

// Module: buffer_mult_seq
// PURPOSE
//  Sequencer for one buffer_mult lane (weight buffer + registered multiplier).
//  Loads a vector of cfg_len weights into the buffer, then streams cfg_len A operands
//  against buffer[0..cfg_len-1]. Tags each product with res_valid once the pipeline
//  latency has elapsed. Sits between the CNN layer scheduler and the buffer_mult datapath.
// PARAMETERS
//  DATA_WID   `CNN_XLEN  operand/product width (signed)
//  ADDR_B     `ADDR_B    buffer address width
//  PIPE_LAT   2          cycles from A accept to valid prod_data (A reg + mult reg)
// PORTS
//  clk        in   1            clock
//  reset      in   1            synchronous, active-high
//  cfg_len    in   ADDR_B+1     vector length, 0..2^ADDR_B; sampled on load_start/run_start
//  load_start in   1            pulse: begin weight load
//  run_start  in   1            pulse: begin multiply pass
//  ld_valid   in   1            weight word valid
//  ld_data    in   DATA_WID     weight word
//  ld_ready   out  1            weight accepted when ld_valid&ld_ready
//  a_valid    in   1            operand A valid
//  a_data     in   DATA_WID     operand A
//  a_ready    out  1            A accepted when a_valid&a_ready
//  wrb        out  1            to buffer_mult.wrb
//  wrb_addr   out  ADDR_B       to buffer_mult.wrb_addr
//  wrb_data   out  DATA_WID     to buffer_mult.wrb_data
//  rdb_addr   out  ADDR_B       to buffer_mult.rdb_addr
//  mult_a     out  DATA_WID     to buffer_mult.A
//  prod_data  in   DATA_WID     from buffer_mult.data_out
//  res_valid  out  1            prod_data valid this cycle
//  res_data   out  DATA_WID     = prod_data
//  busy       out  1            state != IDLE
//  done       out  1            1-cycle pulse at end of run pass
//  acc_out    out  DATA_WID+ADDR_B  dot-product result (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE, cnt=0, len=0, valid pipe cleared; all outputs 0 (acc_out 0).
//  - States: IDLE, LOAD, RUN, DRAIN, DONE.
//  - IDLE: load_start -> LOAD (len<=cfg_len, cnt<=0); else run_start -> RUN.
//    Both same cycle: load wins, run_start dropped. Starts outside IDLE ignored.
//  - cfg_len==0: LOAD returns to IDLE next cycle, no writes; RUN goes to DONE, no issues.
//  - LOAD: ld_ready=1. wrb=ld_valid, wrb_addr=cnt, wrb_data=ld_data (combinational).
//    On accept cnt++; after the len-th accept -> IDLE (ld_ready low from next cycle).
//  - RUN: a_ready=1. rdb_addr=cnt, mult_a=a_data (combinational, same cycle).
//    On accept cnt++, 1 is shifted into vpipe[0]; otherwise 0. Last accept -> DRAIN.
//  - vpipe: PIPE_LAT-deep shift register, shifts every cycle in all states.
//    res_valid = vpipe[PIPE_LAT-1]; res_data = prod_data.
//  - DRAIN: a_ready=0; wait until vpipe all-zero -> DONE. DONE: done=1 for one cycle -> IDLE.
//  - Gaps: a_valid low stalls issue only; in-flight products still retire on time.
//  - cnt wraps never: len <= 2^ADDR_B; cnt is ADDR_B+1 bits, compared to len.
//  - wrb never asserted outside LOAD; rdb_addr holds the last value when not in RUN.
//  - Reset mid-operation: abort immediately to the reset state; in-flight products are
//    discarded (res_valid 0 from the cycle after reset is sampled).
// CONFIGURATION
//  BUFFER_MULT_SEQ_ACCUM_EN defined:
//    - acc cleared on run_start accept.
//    - acc += sign-extended res_data on each res_valid.
//    - acc_out holds the final sum from the done cycle onward, until the next run_start.
//  Undefined: no accumulator logic; acc_out tied to 0.
// TESTING
//  1 load len=4 {1,2,3,4}, ld_valid always 1 -> wrb 4 cycles, addr 0..3, then ld_ready=0
//  2 run len=4, A={5,5,5,5} back-to-back -> res_valid cycles 2..5 after first accept,
//    data {5,10,15,20}; done 1 cycle after last res_valid
//  3 run with a_valid toggling 1010... -> products still {5,10,15,20}, in order, no loss
//  4 load_start&run_start same cycle -> LOAD entered; starts during RUN ignored; len=0 -> done, no res
//  5 reset asserted mid-RUN after 2 accepts -> next cycle busy=0, res_valid=0, no done
//  6 ACCUM_EN: weights {-2,3,4,1}, A={3,3,-1,7} -> acc_out=-6+9-4+7=6 at done

Source files
------------

// File: rtl/buffer_mult_seq.sv
// rtl/buffer_mult_seq.sv - load/run sequencer for one buffer_mult lane
// Optional dot-product accumulator on acc_out: define BUFFER_MULT_SEQ_ACCUM_EN.
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif
`ifndef ADDR_B
`define ADDR_B 4
`endif

module buffer_mult_seq #(
  parameter int DATA_WID = `CNN_XLEN,
  parameter int ADDR_B   = `ADDR_B,
  parameter int PIPE_LAT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_B:0]            i_cfg_len,
  input  logic                       i_load_start,
  input  logic                       i_run_start,
  input  logic                       i_ld_valid,
  input  logic [DATA_WID-1:0]        i_ld_data,
  output logic                       o_ld_ready,
  input  logic                       i_a_valid,
  input  logic [DATA_WID-1:0]        i_a_data,
  output logic                       o_a_ready,
  output logic                       o_wrb,
  output logic [ADDR_B-1:0]          o_wrb_addr,
  output logic [DATA_WID-1:0]        o_wrb_data,
  output logic [ADDR_B-1:0]          o_rdb_addr,
  output logic [DATA_WID-1:0]        o_mult_a,
  input  logic [DATA_WID-1:0]        i_prod_data,
  output logic                       o_res_valid,
  output logic [DATA_WID-1:0]        o_res_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [DATA_WID+ADDR_B-1:0] o_acc_out
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_B:0]     r_cnt;
  logic [ADDR_B:0]     r_len;
  logic [ADDR_B:0]     w_cnt_inc;
  logic [PIPE_LAT-1:0] r_vpipe;
  logic [PIPE_LAT-1:0] w_vpipe_next;
  logic [ADDR_B-1:0]   r_rdb_hold;
  logic                w_more;
  logic                w_last;
  logic                w_ld_acc;
  logic                w_a_acc;
  logic                w_start;

  assign w_cnt_inc    = r_cnt + {{ADDR_B{1'b0}}, 1'b1};
  assign w_more       = (r_cnt < r_len);
  assign w_last       = (w_cnt_inc == r_len);
  assign w_ld_acc     = (r_state == S_LOAD) && w_more && i_ld_valid;
  assign w_a_acc      = (r_state == S_RUN) && w_more && i_a_valid;
  assign w_start      = (r_state == S_IDLE) && (i_load_start || i_run_start);
  assign w_vpipe_next = {r_vpipe[PIPE_LAT-2:0], w_a_acc};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Drain exits when the pipe will be empty next cycle, so done lands right after the last result.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_load_start)     w_next = S_LOAD;
        else if (i_run_start) w_next = S_RUN;
      end
      S_LOAD: begin
        if (!w_more || (w_ld_acc && w_last)) w_next = S_IDLE;
      end
      S_RUN: begin
        if (!w_more)                 w_next = S_DONE;
        else if (w_a_acc && w_last)  w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_vpipe_next == '0) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ld_ready = 1'b0;
    o_wrb      = 1'b0;
    o_wrb_addr = '0;
    o_wrb_data = '0;
    o_a_ready  = 1'b0;
    o_rdb_addr = r_rdb_hold;
    o_mult_a   = '0;
    o_busy     = (r_state != S_IDLE);
    o_done     = (r_state == S_DONE);
    if (r_state == S_LOAD) begin
      o_ld_ready = w_more;
      o_wrb      = w_ld_acc;
      o_wrb_addr = r_cnt[ADDR_B-1:0];
      o_wrb_data = i_ld_data;
    end
    if (r_state == S_RUN) begin
      o_a_ready  = w_more;
      o_rdb_addr = r_cnt[ADDR_B-1:0];
      o_mult_a   = i_a_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_len      <= '0;
      r_vpipe    <= '0;
      r_rdb_hold <= '0;
    end else begin
      r_vpipe <= w_vpipe_next;
      if (w_start) begin
        r_len <= i_cfg_len;
        r_cnt <= '0;
      end else if (w_ld_acc || w_a_acc) begin
        r_cnt <= w_cnt_inc;
      end
      if (r_state == S_RUN) begin
        r_rdb_hold <= r_cnt[ADDR_B-1:0];
      end
    end
  end

  assign o_res_valid = r_vpipe[PIPE_LAT-1];
  assign o_res_data  = i_prod_data;

`ifdef BUFFER_MULT_SEQ_ACCUM_EN
  logic [DATA_WID+ADDR_B-1:0] r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if ((r_state == S_IDLE) && !i_load_start && i_run_start) begin
      r_acc <= '0;
    end else if (o_res_valid) begin
      r_acc <= r_acc + {{ADDR_B{i_prod_data[DATA_WID-1]}}, i_prod_data};
    end
  end

  assign o_acc_out = r_acc;
`else
  assign o_acc_out = '0;
`endif

endmodule

// File: tb/tb_buffer_mult_seq.sv
// tb/tb_buffer_mult_seq.sv - table-driven scoreboard bench for buffer_mult_seq with a buffer_mult model
module tb_buffer_mult_seq;
  localparam int DW = 16;
  localparam int AB = 4;
  localparam int AW = DW + AB;

  logic          clk = 1'b0;
  logic          reset;
  logic [AB:0]   cfg_len;
  logic          load_start, run_start, ld_valid, a_valid;
  logic [DW-1:0] ld_data, a_data, prod_data;
  logic          ld_ready, a_ready, wrb, res_valid, busy, done;
  logic [AB-1:0] wrb_addr, rdb_addr;
  logic [DW-1:0] wrb_data, mult_a, res_data;
  logic [AW-1:0] acc_out;

  always #5 clk = ~clk;

  buffer_mult_seq dut (
    .clk          (clk),
    .reset        (reset),
    .i_cfg_len    (cfg_len),
    .i_load_start (load_start),
    .i_run_start  (run_start),
    .i_ld_valid   (ld_valid),
    .i_ld_data    (ld_data),
    .o_ld_ready   (ld_ready),
    .i_a_valid    (a_valid),
    .i_a_data     (a_data),
    .o_a_ready    (a_ready),
    .o_wrb        (wrb),
    .o_wrb_addr   (wrb_addr),
    .o_wrb_data   (wrb_data),
    .o_rdb_addr   (rdb_addr),
    .o_mult_a     (mult_a),
    .i_prod_data  (prod_data),
    .o_res_valid  (res_valid),
    .o_res_data   (res_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_acc_out    (acc_out)
  );

  // buffer_mult datapath model: weight RAM, A/B registers, registered product
  logic [DW-1:0] mem [16];
  logic [DW-1:0] a_reg = '0, b_reg = '0, prod = '0;
  always @(posedge clk) begin
    if (wrb) mem[wrb_addr] <= wrb_data;
    a_reg <= mult_a;
    b_reg <= mem[rdb_addr];
    prod  <= a_reg * b_reg;
  end
  assign prod_data = prod;

  typedef struct {
    logic [AB:0]         len;
    logic [3:0][DW-1:0]  w;
    logic [3:0][DW-1:0]  a;
    bit                  gappy;
    bit                  poke;
    logic [3:0][DW-1:0]  exp;
    logic [AW-1:0]       acc;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } sb_t;

  vec_t tbl [4];
  sb_t  sb [$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   res_cnt = 0;
  int   done_cnt = 0;
  int   last_res_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (done) done_cnt++;
    if (res_valid) begin
      res_cnt++;
      last_res_cyc = cyc;
      if (sb.size() == 0) begin
        chk("res_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic set_vec(input int idx, input int len, input int w0, w1, w2, w3,
                         input int a0, a1, a2, a3, input bit g, p,
                         input int e0, e1, e2, e3, input int acc);
    tbl[idx].len    = len[AB:0];
    tbl[idx].w[0]   = w0[DW-1:0]; tbl[idx].w[1] = w1[DW-1:0];
    tbl[idx].w[2]   = w2[DW-1:0]; tbl[idx].w[3] = w3[DW-1:0];
    tbl[idx].a[0]   = a0[DW-1:0]; tbl[idx].a[1] = a1[DW-1:0];
    tbl[idx].a[2]   = a2[DW-1:0]; tbl[idx].a[3] = a3[DW-1:0];
    tbl[idx].gappy  = g;
    tbl[idx].poke   = p;
    tbl[idx].exp[0] = e0[DW-1:0]; tbl[idx].exp[1] = e1[DW-1:0];
    tbl[idx].exp[2] = e2[DW-1:0]; tbl[idx].exp[3] = e3[DW-1:0];
    tbl[idx].acc    = acc[AW-1:0];
  endtask

  task automatic load_vec(input vec_t v);
    @(posedge clk); #1;
    cfg_len = v.len; load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0; ld_valid = 1'b1;
    for (int i = 0; i < int'(v.len); i++) begin
      ld_data = v.w[i];
      @(negedge clk);
      chk("ld_ready", ld_ready, 1);
      chk("wrb", wrb, 1);
      chk("wrb_addr", wrb_addr, i);
      chk("wrb_data", wrb_data, v.w[i]);
      @(posedge clk); #1;
    end
    ld_data = 16'hdead;
    @(negedge clk);
    chk("ld_ready_after", ld_ready, 0);
    chk("wrb_after", wrb, 0);
    chk("busy_after_load", busy, 0);
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int  i;
    int  budget;
    bit  got;
    logic [AW-1:0] exp_acc;
`ifdef BUFFER_MULT_SEQ_ACCUM_EN
    exp_acc = v.acc;
`else
    exp_acc = '0;
`endif
    @(posedge clk); #1;
    cfg_len = v.len; run_start = 1'b1;
    @(posedge clk); #1;
    run_start = 1'b0;
    i = 0; budget = 0;
    while (i < int'(v.len) && budget < 50) begin
      a_valid    = v.gappy ? ((budget % 2) == 0) : 1'b1;
      a_data     = v.a[i];
      load_start = v.poke;
      run_start  = v.poke;
      @(negedge clk);
      if (v.poke) chk("start_in_run_ignored", ld_ready, 0);
      if (a_valid && a_ready) begin
        chk("rdb_addr", rdb_addr, i);
        chk("mult_a", mult_a, v.a[i]);
        sb.push_back('{v.exp[i], cyc + 2});
        i++;
      end
      @(posedge clk); #1;
      budget++;
    end
    a_valid = 1'b0; load_start = 1'b0; run_start = 1'b0;
    chk("issue_count", i, v.len);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        chk("done_latency", cyc, last_res_cyc + 1);
        chk("acc_out", acc_out, exp_acc);
      end
      @(posedge clk); #1;
    end
    chk("done_seen", got, 1);
    chk("sb_empty", sb.size(), 0);
    chk("busy_after_run", busy, 0);
  endtask

  initial begin
    int rc, dc;
    reset = 1'b1; cfg_len = '0; load_start = 1'b0; run_start = 1'b0;
    ld_valid = 1'b0; ld_data = '0; a_valid = 1'b0; a_data = '0;
    for (int k = 0; k < 16; k++) mem[k] = '0;

    set_vec(0, 4,  1,  2,  3, 4,  5, 5,   5, 5, 1'b0, 1'b0,   5,  10,  15, 20, 50);
    set_vec(1, 4,  1,  2,  3, 4,  5, 5,   5, 5, 1'b1, 1'b1,   5,  10,  15, 20, 50);
    set_vec(2, 4, -2,  3,  4, 1,  3, 3,  -1, 7, 1'b0, 1'b0,  -6,   9,  -4,  7,  6);
    set_vec(3, 3,  7, -1,  2, 0, -3, 4, 100, 0, 1'b1, 1'b0, -21,  -4, 200,  0, 175);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_wrb", wrb, 0);
    chk("rst_rdb_addr", rdb_addr, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_acc_out", acc_out, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int t = 0; t < 4; t++) begin
      load_vec(tbl[t]);
      run_vec(tbl[t]);
    end

    // both starts together with len 0: LOAD wins and falls back to IDLE without a done
    dc = done_cnt;
    @(posedge clk); #1;
    cfg_len = '0; load_start = 1'b1; run_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0; run_start = 1'b0;
    @(negedge clk);
    chk("len0_load_busy", busy, 1);
    chk("len0_load_ld_ready", ld_ready, 0);
    chk("len0_load_a_ready", a_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("len0_load_idle", busy, 0);
    chk("len0_load_no_done", done_cnt, dc);

    // run with len 0: straight to DONE, no products
    rc = res_cnt;
    @(posedge clk); #1;
    run_start = 1'b1;
    @(posedge clk); #1;
    run_start = 1'b0;
    @(negedge clk);
    chk("len0_run_busy", busy, 1);
    chk("len0_run_a_ready", a_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("len0_run_done", done, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("len0_run_idle", busy, 0);
    chk("len0_run_no_res", res_cnt, rc);

    // reset mid-run after two accepts
    load_vec(tbl[0]);
    @(posedge clk); #1;
    cfg_len = 5'd4; run_start = 1'b1;
    @(posedge clk); #1;
    run_start = 1'b0; a_valid = 1'b1; a_data = 16'd5;
    sb.push_back('{16'd5, cyc + 2});
    @(posedge clk); #1;
    sb.push_back('{16'd10, cyc + 2});
    @(posedge clk); #1;
    a_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    rc = res_cnt; dc = done_cnt;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_done", done, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("abort_no_res", res_cnt, rc);
    chk("abort_no_done", done_cnt, dc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
